// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns "rotate N detents" commands into A/B Gray-code waveforms
// with programmable phase spacing and optional contact-bounce glitches on the changing line.
module quad_encoder_gen #(
    parameter int unsigned PHASE_TICKS   = 400,
    parameter int unsigned BOUNCE_PULSES = 0,
    parameter int unsigned BOUNCE_TICKS  = 3,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned POS_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             Aout,
    output logic             Bout,
    output logic             busy,
    output logic             edge_pulse,
    output logic             done,
    output logic [POS_W-1:0] position
);

    localparam int unsigned TW = $clog2(PHASE_TICKS + 1);
    localparam int unsigned BW = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
    localparam int unsigned GW = $clog2(2 * BOUNCE_PULSES + 2);
    localparam int unsigned EW = CNT_W + 2;

    typedef enum logic [2:0] {StIdle, StEdge, StBounce, StHold, StDone} state_e;

    state_e          state_q;
    logic            dir_q;
    logic [1:0]      idx_q;
    logic [1:0]      chg_q;
    logic [EW-1:0]   edges_left_q;
    logic [TW-1:0]   tick_q;
    logic [BW-1:0]   btick_q;
    logic [GW-1:0]   toggles_q;

    logic [1:0]      idx_nxt;
    logic [1:0]      ab_nxt;
    logic [1:0]      ab_cur;
    logic            tick_last;
    state_e          after_hold;

    // Gray map: index 0..3 -> {A,B} = 00, 10, 11, 01
    function automatic logic [1:0] gray(input logic [1:0] i);
        return {i[1] ^ i[0], i[1]};
    endfunction

    always_comb begin
        idx_nxt    = dir_q ? idx_q + 2'd1 : idx_q - 2'd1;
        ab_nxt     = gray(idx_nxt);
        ab_cur     = gray(idx_q);
        // The EDGE cycle itself is the PHASE_TICKS-th tick, so leave HOLD one tick early.
        tick_last  = (tick_q == TW'(PHASE_TICKS - 1));
        after_hold = (edges_left_q != '0) ? StEdge : StDone;
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dir_q        <= 1'b0;
            idx_q        <= 2'd0;
            chg_q        <= 2'b00;
            edges_left_q <= '0;
            tick_q       <= '0;
            btick_q      <= '0;
            toggles_q    <= '0;
            Aout         <= 1'b0;
            Bout         <= 1'b0;
            edge_pulse   <= 1'b0;
            done         <= 1'b0;
            cmd_ready    <= 1'b0;
            position     <= '0;
        end else begin
            edge_pulse <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        dir_q     <= cmd_dir;
                        if (cmd_count == '0) begin
                            state_q <= StDone;
                        end else begin
                            edges_left_q <= {cmd_count, 2'b00};
                            state_q      <= StEdge;
                        end
                    end
                end
                StEdge: begin
                    idx_q        <= idx_nxt;
                    {Aout, Bout} <= ab_nxt;
                    chg_q        <= ab_nxt ^ ab_cur;
                    edge_pulse   <= 1'b1;
                    edges_left_q <= edges_left_q - EW'(1);
                    tick_q       <= TW'(1);
                    if (idx_nxt == 2'd0) begin
                        position <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
                    end
                    if (BOUNCE_PULSES > 0) begin
                        btick_q   <= '0;
                        toggles_q <= GW'(2 * BOUNCE_PULSES);
                        state_q   <= StBounce;
                    end else begin
                        state_q <= StHold;
                    end
                end
                StBounce: begin
                    tick_q <= tick_q + TW'(1);
                    if (btick_q == BW'(BOUNCE_TICKS - 1)) begin
                        btick_q      <= '0;
                        {Aout, Bout} <= {Aout, Bout} ^ chg_q;
                        toggles_q    <= toggles_q - GW'(1);
                        // Bounce may legally end on the very last tick of the phase.
                        if (toggles_q == GW'(1)) begin
                            state_q <= tick_last ? after_hold : StHold;
                        end
                    end else begin
                        btick_q <= btick_q + BW'(1);
                    end
                end
                StHold: begin
                    tick_q <= tick_q + TW'(1);
                    if (tick_last) begin
                        state_q <= after_hold;
                    end
                end
                StDone: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
- Transmitter-side counterpart of the PMOD rotary-encoder receive path.
- Accepts "rotate N detents in direction D" commands over a valid/ready handshake.
- Drives A/B quadrature lines with programmable phase timing and optional contact-bounce injection.
- Used as an encoder emulator for driving the debouncer/decoder chain on hardware and as a loopback stimulus source.

Parameters:
- PHASE_TICKS, 400, clocks from one quadrature edge to the next (≥ 4).
- BOUNCE_PULSES, 0, extra glitch pulses injected on the changing line after each edge.
- BOUNCE_TICKS, 3, clocks per glitch half-period; required: 2*BOUNCE_PULSES*BOUNCE_TICKS < PHASE_TICKS.
- CNT_W, 8, width of cmd_count.
- POS_W, 16, width of position counter.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: generator idle and able to accept a command.
- cmd_dir, in, 1: 1 = clockwise (A leads B), 0 = counter-clockwise.
- cmd_count, in, CNT_W: number of detents; 1 detent = 4 quadrature edges.
- Aout, out, 1: quadrature channel A (registered).
- Bout, out, 1: quadrature channel B (registered).
- busy, out, 1: high while a command executes.
- edge_pulse, out, 1: one-cycle pulse in the cycle a nominal quadrature edge appears on Aout/Bout.
- done, out, 1: one-cycle pulse when a command completes.
- position, out, POS_W: signed detent count, +1 per completed CW detent, −1 per CCW detent; wraps modulo 2^POS_W.

Behaviour:
- Reset (synchronous, priority over everything): Aout=0, Bout=0, phase index=0, position=0, busy=0, done=0, edge_pulse=0, cmd_ready=0 during rst and 1 from the first cycle after. Reset mid-command aborts it: lines go to 00 on the next edge, no done pulse, position cleared.
- Gray sequence, phase index 0..3 → {Aout,Bout} = 00, 10, 11, 01.
  - CW: index+1 mod 4 per edge.
  - CCW: index−1 mod 4 per edge.
  - Index persists between commands. At rest after completed commands the index is always 0, because commands are whole detents.
- States:
  - IDLE: cmd_ready=1. Handshake fires when cmd_valid && cmd_ready; latch dir and count. count=0 → go to DONE. Otherwise load edges_left = 4*count and go to EDGE.
  - EDGE: one cycle after acceptance (latency 1).
    - Update index and drive the new {Aout,Bout}; edge_pulse=1.
    - Decrement edges_left; reset tick counter to 1.
    - Go to BOUNCE if BOUNCE_PULSES>0, else HOLD.
  - BOUNCE:
    - Only the line that changed in EDGE toggles: inverted for BOUNCE_TICKS clocks, restored for BOUNCE_TICKS clocks, BOUNCE_PULSES times.
    - The tick counter keeps running; go to HOLD afterwards.
    - edge_pulse is not asserted on bounce toggles.
  - HOLD: lines steady at nominal value until tick counter reaches PHASE_TICKS.
    - Then, if edges_left>0, go to EDGE. Consecutive nominal edges are therefore exactly PHASE_TICKS clocks apart.
    - Otherwise go to DONE.
  - DONE: done=1 for one cycle, go to IDLE. cmd_ready returns the cycle after DONE.
- busy=1 in EDGE, BOUNCE, HOLD, DONE.
- position updates in the EDGE cycle whose new index is 0 (detent complete): +1 if CW, −1 if CCW.
- cmd_valid while busy is ignored; no queuing. The command is held by the sender until ready.
- Total command duration for count=N>0: acceptance → done = 4*N*PHASE_TICKS + 1 clocks.
- count = 2^CNT_W−1 must not overflow edges_left; edges_left is CNT_W+2 bits.

Test Plan:
- Reset then idle 10 clocks → Aout=Bout=0, cmd_ready=1, busy=0, position=0.
- PHASE_TICKS=8, cmd dir=1 count=1 → edges at +1,+9,+17,+25 clocks with AB=10,11,01,00; done at +33; position=1; 4 edge_pulses.
- Same with dir=0 count=2 → AB=01,11,10,00 repeated twice; position=−2 (0xFFFE); done after 65 clocks.
- BOUNCE_PULSES=2, BOUNCE_TICKS=1, PHASE_TICKS=8, CW count=1 → after first edge A reads 1,0,1,0,1 then steady; B unchanged; next nominal edge still 8 clocks after the first.
- cmd count=0 → done pulse 1 cycle after acceptance, no line change; cmd_valid held during busy → not accepted until cmd_ready.
- rst asserted mid-command (AB=11) → next cycle AB=00, busy=0, position=0, no done; a new command runs normally. Loopback through the debouncer/decoder with default params: decoded count equals commanded detents.
